// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte watchdog: counts enabled idle cycles and flags the last one of TO_CYC.
module uart_timeout_cnt #(
    parameter int TO_CYC = 156240
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // A byte in the expiry cycle clears the count instead of expiring it.
    assign expired = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || !en || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_rx_ctrl.sv
// Frame sequencer behind the UART receiver: header/length/payload/checksum parsing,
// payload buffering and release of checksum-valid frames over a valid/ready stream.
module uart_frame_rx_ctrl
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         BAUD_RATE     = 9600,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] HEADER        = DEFAULT_HEADER,
    parameter int         TIMEOUT_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int TO_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] rd_q, rd_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       wr_en;
    logic       to_en;
    logic       to_exp;

    logic [7:0] pbuf [MAX_LEN];

    uart_timeout_cnt #(
        .TO_CYC (TO_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid),
        .en      (to_en),
        .expired (to_exp)
    );

    assign to_en     = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
    assign busy      = (state_q != HUNT);
    assign m_valid   = (state_q == DRAIN);
    assign m_last    = m_valid && (rd_q == len_q - 8'd1);
    assign m_data    = m_valid ? pbuf[rd_q[AW-1:0]] : 8'h00;
    assign frame_len = frame_len_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        rd_d        = rd_q;
        frame_len_d = frame_len_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        wr_en       = 1'b0;

        case (state_q)
            HUNT: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d = LEN;
                    sum_d   = 8'h00;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = HUNT;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        idx_d   = 8'h00;
                        state_d = PAYLOAD;
                    end
                end else if (to_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
            PAYLOAD: begin
                // Header-valued bytes here are ordinary data; no resync.
                if (rx_valid) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) begin
                        state_d = CSUM;
                    end
                end else if (to_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        ok_d        = 1'b1;
                        frame_len_d = len_q;
                        rd_d        = 8'h00;
                        state_d     = DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = HUNT;
                    end
                end else if (to_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = HUNT;
                end
            end
            DRAIN: begin
                // Bytes arriving while the buffer drains are dropped and flagged.
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                if (m_ready) begin
                    if (m_last) begin
                        rd_d    = 8'h00;
                        state_d = HUNT;
                    end else begin
                        rd_d = rd_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            len_q       <= 8'h00;
            idx_q       <= 8'h00;
            sum_q       <= 8'h00;
            rd_q        <= 8'h00;
            frame_len_q <= 8'h00;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            rd_q        <= rd_d;
            frame_len_q <= frame_len_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pbuf[idx_q[AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Scoreboard bench for uart_frame_rx_ctrl with a shortened timeout (TO_CYC = 300).
module tb_uart_frame_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // beat = {frame_len, m_last, m_data}; event = {frame_ok, frame_err, err_code}
    logic [16:0] beatq [$];
    logic [3:0]  evq [$];
    logic [16:0] e_beat;
    logic [3:0]  e_ev;

    uart_frame_rx_ctrl #(
        .CLK_FREQ      (1000),
        .BAUD_RATE     (100),
        .MAX_LEN       (16),
        .HEADER        (8'hA5),
        .TIMEOUT_BYTES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_len (frame_len),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_beat(input logic [7:0] d, input logic last, input logic [7:0] len);
        beatq.push_back({len, last, d});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: compare every handshake beat and every status pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (beatq.size() == 0) begin
                    chk("unexpected_beat", {15'd0, frame_len, m_last, m_data}, 32'h1FFFF);
                end else begin
                    e_beat = beatq.pop_front();
                    chk("beat", {15'd0, frame_len, m_last, m_data}, {15'd0, e_beat});
                end
            end
            if (frame_ok || frame_err) begin
                if (evq.size() == 0) begin
                    chk("unexpected_event", {28'd0, frame_ok, frame_err, err_code}, 32'hF);
                end else begin
                    e_ev = evq.pop_front();
                    chk("event", {28'd0, frame_ok, frame_err, frame_ok ? 2'b00 : err_code},
                        {28'd0, e_ev});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {12'd0, m_valid, m_last, m_data, frame_len, frame_ok, frame_err,
            err_code, busy}, 32'd0);
        rst = 1'b0;

        // Good frame, consumer always ready.
        m_ready = 1'b1;
        evq.push_back(4'b1000);
        push_beat(8'h11, 1'b0, 8'd2);
        push_beat(8'h22, 1'b1, 8'd2);
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
        chk("good_busy", {31'd0, busy}, 32'd1);
        send(8'h35);
        chk("good_ok_mvalid", {30'd0, frame_ok, m_valid}, 32'd3);
        chk("good_frame_len", {24'd0, frame_len}, 32'd2);
        wait_idle();

        // Backpressure at the start of the drain.
        m_ready = 1'b0;
        evq.push_back(4'b1000);
        push_beat(8'h11, 1'b0, 8'd2);
        push_beat(8'h22, 1'b1, 8'd2);
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h35);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, 1'b0, 8'h11});
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_second", {22'd0, busy, m_last, m_data}, {22'd0, 1'b1, 1'b1, 8'h22});
        @(posedge clk);
        #1;
        chk("bp_done", {30'd0, busy, m_valid}, 32'd0);

        // Checksum error.
        evq.push_back({2'b01, 2'd1});
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h36);
        chk("csum_err", {28'd0, frame_err, err_code, m_valid}, {28'd0, 1'b1, 2'd1, 1'b0});
        chk("csum_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("csum_no_valid", {31'd0, m_valid}, 32'd0);

        // Length errors, then recovery with a one-byte frame.
        evq.push_back({2'b01, 2'd0});
        send(8'hA5); send(8'h00);
        chk("len_zero", {29'd0, frame_err, err_code}, {29'd0, 1'b1, 2'd0});
        evq.push_back({2'b01, 2'd0});
        send(8'hA5); send(8'h11);
        chk("len_big", {29'd0, frame_err, err_code}, {29'd0, 1'b1, 2'd0});
        evq.push_back(4'b1000);
        push_beat(8'h7F, 1'b1, 8'd1);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("len_recover_ok", {31'd0, frame_ok}, 32'd1);
        wait_idle();

        // Timeout: 300 silent cycles after the last byte.
        evq.push_back({2'b01, 2'd2});
        send(8'hA5); send(8'h03); send(8'h01);
        repeat (299) @(posedge clk);
        #1;
        chk("to_not_yet", {30'd0, frame_err, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("to_expired", {28'd0, frame_err, err_code, busy}, {28'd0, 1'b1, 2'd2, 1'b0});

        // Byte landing on the expiry cycle wins.
        send(8'hA5); send(8'h03); send(8'h01);
        repeat (299) @(posedge clk);
        #1;
        send(8'h02);
        chk("to_byte_wins", {30'd0, frame_err, busy}, 32'd1);
        evq.push_back(4'b1000);
        push_beat(8'h01, 1'b0, 8'd3);
        push_beat(8'h02, 1'b0, 8'd3);
        push_beat(8'h03, 1'b1, 8'd3);
        send(8'h03); send(8'h09);
        wait_idle();

        // Overrun during a stalled drain.
        m_ready = 1'b0;
        evq.push_back(4'b1000);
        evq.push_back({2'b01, 2'd3});
        evq.push_back({2'b01, 2'd3});
        push_beat(8'h11, 1'b0, 8'd2);
        push_beat(8'h22, 1'b1, 8'd2);
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h35);
        send(8'hA5);
        chk("ovr_first", {29'd0, frame_err, err_code}, {29'd0, 1'b1, 2'd3});
        send(8'h33);
        chk("ovr_data_held", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'h11});
        m_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a payload.
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_outputs", {12'd0, m_valid, m_last, m_data, frame_len, frame_ok, frame_err,
            err_code, busy}, 32'd0);
        rst = 1'b0;
        evq.push_back(4'b1000);
        push_beat(8'h7F, 1'b1, 8'd1);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        chk("events_all_seen", 32'(evq.size()), 32'd0);
        chk("beats_all_seen", 32'(beatq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
